id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus EX-stage operand forwarding. Sits directly upstream of the execute ALU.
- Captures decoded operands and control from the decode stage, resolves data hazards from the EX/MEM and MEM/WB stages, and drives the ALU's a_input, b_input, sa and opcode.
- Detects load-use hazards and inserts bubbles into the pipeline.

---
 rtl/id_ex_operand_stage_if.sv | 56 +++++
 rtl/id_ex_operand_stage.sv | 111 +++++++++++
 tb/tb_id_ex_operand_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// Bundle between decode/forwarding sources and the ID/EX operand stage feeding the ALU.
// Master drives decode, stall/flush and forwarding inputs; slave is the operand stage itself.
interface id_ex_operand_stage_if #(
   parameter int WORD_WIDTH = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  stall;
   logic                  flush;
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs;
   logic [REG_ADDR_W-1:0] id_rt;
   logic [REG_ADDR_W-1:0] id_rd;
   logic [WORD_WIDTH-1:0] id_rs_data;
   logic [WORD_WIDTH-1:0] id_rt_data;
   logic [WORD_WIDTH-1:0] id_imm;
   logic [4:0]            id_sa;
   logic [4:0]            id_opcode;
   logic                  id_use_imm;
   logic                  id_reg_write;
   logic                  id_mem_read;
   logic                  id_mem_write;
   logic                  exmem_reg_write;
   logic [REG_ADDR_W-1:0] exmem_rd;
   logic [WORD_WIDTH-1:0] exmem_result;
   logic                  memwb_reg_write;
   logic [REG_ADDR_W-1:0] memwb_rd;
   logic [WORD_WIDTH-1:0] memwb_result;

   logic                  ex_valid;
   logic [WORD_WIDTH-1:0] a_input;
   logic [WORD_WIDTH-1:0] b_input;
   logic [4:0]            sa;
   logic [4:0]            opcode;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_reg_write;
   logic                  ex_mem_read;
   logic                  ex_mem_write;
   logic [WORD_WIDTH-1:0] ex_store_data;
   logic                  load_use_hazard;

   modport master (
      output stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
             id_sa, id_opcode, id_use_imm, id_reg_write, id_mem_read, id_mem_write,
             exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
      input  ex_valid, a_input, b_input, sa, opcode, ex_rd, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_store_data, load_use_hazard
   );

   modport slave (
      input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
             id_sa, id_opcode, id_use_imm, id_reg_write, id_mem_read, id_mem_write,
             exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
      output ex_valid, a_input, b_input, sa, opcode, ex_rd, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_store_data, load_use_hazard
   );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with EX-stage operand forwarding; outputs 1 cycle after capture, forwarding same-cycle.
// Stall holds the stage; flush or a load-use hazard loads a bubble (flush > stall > hazard > load).
module id_ex_operand_stage #(
   parameter int WORD_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input logic                  clk,
   input logic                  rst_n,
   id_ex_operand_stage_if.slave bus
);
   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
      logic [WORD_WIDTH-1:0] rs_data;
      logic [WORD_WIDTH-1:0] rt_data;
      logic [WORD_WIDTH-1:0] imm;
      logic [4:0]            sa;
      logic [4:0]            opcode;
      logic                  use_imm;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
   } stage_t;

   stage_t                r_stage;
   stage_t                w_load;
   logic                  w_hazard;
   logic                  w_rs_byp;
   logic                  w_rt_byp;
   logic [WORD_WIDTH-1:0] w_fwd_rs;
   logic [WORD_WIDTH-1:0] w_fwd_rt;

   function automatic logic [WORD_WIDTH-1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] idx,
      input logic [WORD_WIDTH-1:0] reg_dat,
      input logic                  exm_we,
      input logic [REG_ADDR_W-1:0] exm_rd,
      input logic [WORD_WIDTH-1:0] exm_res,
      input logic                  wb_we,
      input logic [REG_ADDR_W-1:0] wb_rd,
      input logic [WORD_WIDTH-1:0] wb_res
   );
      logic [WORD_WIDTH-1:0] sel;
      sel = reg_dat;
      // The younger EX/MEM result shadows MEM/WB; r0 is hard-wired zero and never forwarded.
      if (exm_we && (exm_rd != '0) && (exm_rd == idx))
         sel = exm_res;
      else if (wb_we && (wb_rd != '0) && (wb_rd == idx))
         sel = wb_res;
      return sel;
   endfunction

   // Register file write and read happen in the same cycle, so catch the writeback value here.
   assign w_rs_byp = bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.id_rs);
   assign w_rt_byp = bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == bus.id_rt);

   assign w_hazard = r_stage.valid && r_stage.mem_read && bus.id_valid && (r_stage.rd != '0) &&
                     ((r_stage.rd == bus.id_rs) ||
                      ((r_stage.rd == bus.id_rt) && (!bus.id_use_imm || bus.id_mem_write)));

   always_comb begin
      w_load           = '0;
      w_load.valid     = bus.id_valid;
      w_load.rs        = bus.id_rs;
      w_load.rt        = bus.id_rt;
      w_load.rd        = bus.id_rd;
      w_load.rs_data   = w_rs_byp ? bus.memwb_result : bus.id_rs_data;
      w_load.rt_data   = w_rt_byp ? bus.memwb_result : bus.id_rt_data;
      w_load.imm       = bus.id_imm;
      w_load.sa        = bus.id_sa;
      w_load.opcode    = bus.id_opcode;
      w_load.use_imm   = bus.id_use_imm;
      w_load.reg_write = bus.id_valid && bus.id_reg_write;
      w_load.mem_read  = bus.id_valid && bus.id_mem_read;
      w_load.mem_write = bus.id_valid && bus.id_mem_write;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stage <= '0;
      else if (bus.flush)
         r_stage <= '0;
      else if (bus.stall)
         r_stage <= r_stage;
      else if (w_hazard)
         r_stage <= '0;
      else
         r_stage <= w_load;
   end

   assign w_fwd_rs = fwd_sel(r_stage.rs, r_stage.rs_data,
                             bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                             bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
   assign w_fwd_rt = fwd_sel(r_stage.rt, r_stage.rt_data,
                             bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                             bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);

   assign bus.ex_valid        = r_stage.valid;
   assign bus.a_input         = w_fwd_rs;
   assign bus.b_input         = r_stage.use_imm ? r_stage.imm : w_fwd_rt;
   assign bus.ex_store_data   = w_fwd_rt;
   assign bus.sa              = r_stage.sa;
   assign bus.opcode          = r_stage.opcode;
   assign bus.ex_rd           = r_stage.rd;
   assign bus.ex_reg_write    = r_stage.reg_write;
   assign bus.ex_mem_read     = r_stage.mem_read;
   assign bus.ex_mem_write    = r_stage.mem_write;
   assign bus.load_use_hazard = w_hazard;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: vector table plus hand sequences for load-use, stall/flush and reset.
module tb_id_ex_operand_stage;
   localparam int W  = 32;
   localparam int RA = 5;

   typedef struct packed {
      logic valid; logic [RA-1:0] rs; logic [RA-1:0] rt; logic [RA-1:0] rd;
      logic [W-1:0] rs_data; logic [W-1:0] rt_data; logic [W-1:0] imm;
      logic [4:0] sa; logic [4:0] opcode;
      logic use_imm; logic rw; logic mr; logic mw;
   } id_t;

   typedef struct packed {
      logic exm_we; logic [RA-1:0] exm_rd; logic [W-1:0] exm_res;
      logic wb_we;  logic [RA-1:0] wb_rd;  logic [W-1:0] wb_res;
   } fw_t;

   typedef struct packed {
      logic valid; logic [W-1:0] a; logic [W-1:0] b; logic [4:0] sa; logic [4:0] op;
      logic [RA-1:0] rd; logic rw; logic mr; logic mw; logic [W-1:0] sd; logic haz;
   } exp_t;

   typedef struct packed {
      id_t  id;
      fw_t  cap;
      fw_t  fw;
      exp_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];
   vec_t vt[9];

   always #5 clk = ~clk;

   id_ex_operand_stage_if #(.WORD_WIDTH(W), .REG_ADDR_W(RA)) bif ();

   id_ex_operand_stage #(.WORD_WIDTH(W), .REG_ADDR_W(RA)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   function automatic id_t mk_id(input logic [31:0] v, rs, rt, rd, rsd, rtd, imm, sa, op, ui, rw, mr, mw);
      id_t d;
      d.valid = v[0]; d.rs = rs[RA-1:0]; d.rt = rt[RA-1:0]; d.rd = rd[RA-1:0];
      d.rs_data = rsd; d.rt_data = rtd; d.imm = imm; d.sa = sa[4:0]; d.opcode = op[4:0];
      d.use_imm = ui[0]; d.rw = rw[0]; d.mr = mr[0]; d.mw = mw[0];
      return d;
   endfunction

   function automatic fw_t mk_fw(input logic [31:0] ewe, erd, eres, wwe, wrd, wres);
      fw_t f;
      f.exm_we = ewe[0]; f.exm_rd = erd[RA-1:0]; f.exm_res = eres;
      f.wb_we = wwe[0]; f.wb_rd = wrd[RA-1:0]; f.wb_res = wres;
      return f;
   endfunction

   function automatic exp_t mk_exp(input logic [31:0] v, a, b, sa, op, rd, rw, mr, mw, sd, haz);
      exp_t e;
      e.valid = v[0]; e.a = a; e.b = b; e.sa = sa[4:0]; e.op = op[4:0]; e.rd = rd[RA-1:0];
      e.rw = rw[0]; e.mr = mr[0]; e.mw = mw[0]; e.sd = sd; e.haz = haz[0];
      return e;
   endfunction

   task automatic drive_id(input id_t d);
      bif.id_valid = d.valid; bif.id_rs = d.rs; bif.id_rt = d.rt; bif.id_rd = d.rd;
      bif.id_rs_data = d.rs_data; bif.id_rt_data = d.rt_data; bif.id_imm = d.imm;
      bif.id_sa = d.sa; bif.id_opcode = d.opcode; bif.id_use_imm = d.use_imm;
      bif.id_reg_write = d.rw; bif.id_mem_read = d.mr; bif.id_mem_write = d.mw;
   endtask

   task automatic drive_fw(input fw_t f);
      bif.exmem_reg_write = f.exm_we; bif.exmem_rd = f.exm_rd; bif.exmem_result = f.exm_res;
      bif.memwb_reg_write = f.wb_we;  bif.memwb_rd = f.wb_rd;  bif.memwb_result = f.wb_res;
   endtask

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
      end
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got nothing to compare, expected one entry", tag);
      end else begin
         e = sb_q.pop_front();
         chk({tag, ".ex_valid"},      32'(bif.ex_valid),        32'(e.valid));
         chk({tag, ".a_input"},       bif.a_input,              e.a);
         chk({tag, ".b_input"},       bif.b_input,              e.b);
         chk({tag, ".sa"},            32'(bif.sa),              32'(e.sa));
         chk({tag, ".opcode"},        32'(bif.opcode),          32'(e.op));
         chk({tag, ".ex_rd"},         32'(bif.ex_rd),           32'(e.rd));
         chk({tag, ".ex_reg_write"},  32'(bif.ex_reg_write),    32'(e.rw));
         chk({tag, ".ex_mem_read"},   32'(bif.ex_mem_read),     32'(e.mr));
         chk({tag, ".ex_mem_write"},  32'(bif.ex_mem_write),    32'(e.mw));
         chk({tag, ".ex_store_data"}, bif.ex_store_data,        e.sd);
         chk({tag, ".load_use"},      32'(bif.load_use_hazard), 32'(e.haz));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      fw_t   none;
      id_t   add_id;
      exp_t  add_exp;
      exp_t  zero_exp;
      exp_t  ld_exp;

      none     = mk_fw(0, 0, 0, 0, 0, 0);
      add_id   = mk_id(1, 1, 2, 3, 5, 7, 0, 0, 1, 0, 1, 0, 0);
      add_exp  = mk_exp(1, 5, 7, 0, 1, 3, 1, 0, 0, 7, 0);
      zero_exp = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // id fields: valid rs rt rd rs_data rt_data imm sa op use_imm rw mr mw
      vt[0] = '{add_id, none, none, add_exp};
      vt[1] = '{mk_id(1, 3, 2, 5, 'h11, 'h22, 0, 4, 2, 0, 1, 0, 0), none,
                mk_fw(1, 3, 'h1234, 1, 3, 'h9999),
                mk_exp(1, 'h1234, 'h22, 4, 2, 5, 1, 0, 0, 'h22, 0)};
      vt[2] = '{mk_id(1, 3, 2, 5, 'h11, 'h22, 0, 4, 2, 0, 1, 0, 0), none,
                mk_fw(1, 0, 'h1234, 0, 0, 0),
                mk_exp(1, 'h11, 'h22, 4, 2, 5, 1, 0, 0, 'h22, 0)};
      vt[3] = '{mk_id(1, 3, 2, 5, 'h11, 'h22, 0, 4, 2, 0, 1, 0, 0), none,
                mk_fw(1, 0, 'h1234, 1, 3, 'h9999),
                mk_exp(1, 'h9999, 'h22, 4, 2, 5, 1, 0, 0, 'h22, 0)};
      vt[4] = '{mk_id(1, 6, 7, 0, 'h100, 'h55, 'hFFFFFFF0, 0, 3, 1, 0, 0, 1), none, none,
                mk_exp(1, 'h100, 'hFFFFFFF0, 0, 3, 0, 0, 0, 1, 'h55, 0)};
      vt[5] = '{mk_id(1, 9, 4, 10, 'h77, 0, 0, 0, 1, 0, 1, 0, 0),
                mk_fw(0, 0, 0, 1, 4, 'hABCD), none,
                mk_exp(1, 'h77, 'hABCD, 0, 1, 10, 1, 0, 0, 'hABCD, 0)};
      vt[6] = '{mk_id(1, 0, 5, 13, 'h33, 'h44, 0, 0, 1, 0, 1, 0, 0),
                mk_fw(0, 0, 0, 1, 0, 'hDEAD), mk_fw(1, 0, 'hBEEF, 0, 0, 0),
                mk_exp(1, 'h33, 'h44, 0, 1, 13, 1, 0, 0, 'h44, 0)};
      vt[7] = '{mk_id(0, 1, 2, 12, 'hA, 'hB, 0, 3, 5, 0, 1, 1, 1), none, none,
                mk_exp(0, 'hA, 'hB, 3, 5, 12, 0, 0, 0, 'hB, 0)};
      vt[8] = '{mk_id(1, 11, 12, 14, 1, 2, 0, 0, 4, 0, 1, 0, 0), none,
                mk_fw(1, 12, 'hC0, 1, 11, 'hB0),
                mk_exp(1, 'hB0, 'hC0, 0, 4, 14, 1, 0, 0, 'hC0, 0)};

      bif.stall = 1'b0;
      bif.flush = 1'b0;
      drive_id(mk_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      drive_fw(none);

      #3;
      sb_q.push_back(zero_exp);
      check_out("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         drive_id(vt[i].id);
         drive_fw(vt[i].cap);
         sb_q.push_back(vt[i].exp);
         @(posedge clk);
         #1;
         drive_fw(vt[i].fw);
         #1;
         check_out($sformatf("vec%0d", i));
      end

      // Load-use: a load to r8 sits in the stage while decode probes different source patterns.
      @(negedge clk);
      drive_fw(none);
      drive_id(mk_id(1, 1, 2, 8, 'h10, 'h20, 0, 0, 6, 1, 1, 1, 0));
      ld_exp = mk_exp(1, 'h10, 0, 0, 6, 8, 1, 1, 0, 'h20, 0);
      sb_q.push_back(ld_exp);
      @(posedge clk);
      #2;
      check_out("ld");
      drive_id(mk_id(1, 3, 8, 9, 0, 0, 0, 0, 1, 1, 1, 0, 0));
      #1; ld_exp.haz = 1'b0; sb_q.push_back(ld_exp); check_out("lu_rt_imm");
      drive_id(mk_id(1, 3, 8, 9, 0, 0, 0, 0, 1, 1, 0, 0, 1));
      #1; ld_exp.haz = 1'b1; sb_q.push_back(ld_exp); check_out("lu_rt_store");
      drive_id(mk_id(1, 3, 8, 9, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      #1; ld_exp.haz = 1'b1; sb_q.push_back(ld_exp); check_out("lu_rt_reg");
      drive_id(mk_id(0, 8, 3, 9, 0, 0, 0, 0, 1, 0, 1, 0, 0));
      #1; ld_exp.haz = 1'b0; sb_q.push_back(ld_exp); check_out("lu_invalid");
      drive_id(mk_id(1, 8, 3, 9, 'h5A, 'h6B, 0, 0, 1, 0, 1, 0, 0));
      #1; ld_exp.haz = 1'b1; sb_q.push_back(ld_exp); check_out("lu_rs");
      sb_q.push_back(zero_exp);
      @(posedge clk);
      #2;
      check_out("lu_bubble");

      // Flush beats stall; then stall alone holds the stage for three edges.
      @(negedge clk);
      drive_id(add_id);
      sb_q.push_back(add_exp);
      @(posedge clk);
      #2;
      check_out("sf_load");
      bif.stall = 1'b1;
      bif.flush = 1'b1;
      sb_q.push_back(zero_exp);
      @(posedge clk);
      #2;
      check_out("sf_bubble");
      bif.stall = 1'b0;
      bif.flush = 1'b0;
      sb_q.push_back(add_exp);
      @(posedge clk);
      #2;
      check_out("st_load");
      bif.stall = 1'b1;
      drive_id(vt[8].id);
      for (int c = 0; c < 3; c++) begin
         sb_q.push_back(add_exp);
         @(posedge clk);
         #2;
         check_out($sformatf("stall%0d", c));
      end
      bif.stall = 1'b0;

      // Asynchronous reset pulse between edges while a valid ADD is held.
      @(negedge clk);
      drive_id(add_id);
      sb_q.push_back(add_exp);
      @(posedge clk);
      #2;
      check_out("rst_pre");
      rst_n = 1'b0;
      #1;
      sb_q.push_back(zero_exp);
      check_out("rst_async");
      #1;
      rst_n = 1'b1;
      sb_q.push_back(add_exp);
      @(posedge clk);
      #2;
      check_out("rst_resume");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
